// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage RISC pipeline.
//
// Consumes the EX/MEM register, performs loads/stores over a single-outstanding
// req/ack data-memory port and produces the registered MEM/WB register. While an
// access is pending the upstream pipeline is stalled; a watchdog abandons any
// access that stays un-acked for too long.
//
// Parameters:
//   MAX_WAIT      cycles a request may stay un-acked (1..255, default 15)
//
// Ports:
//   clk           in   pipeline clock (rising edge)
//   rst           in   asynchronous active-high reset
//   ex_mem_i      in   EX/MEM register (held stable by upstream while stalled)
//   mem_wb_o      out  registered MEM/WB register
//   stall_o       out  combinational stall of IF..EX/MEM
//   dmem_req_o    out  memory request
//   dmem_we_o     out  1 = store, 0 = load
//   dmem_addr_o   out  byte address
//   dmem_wdata_o  out  store data
//   dmem_ack_i    in   access complete (may coincide with the first request)
//   dmem_rdata_i  in   load data, valid with dmem_ack_i on loads
//   bus_err_o     out  registered one-cycle pulse on watchdog expiry
//   misalign_o    out  registered one-cycle pulse on a misaligned access
//                      (present only with MEM_STAGE_ALIGN_CHECK_EN)
//
// Build option:
//   MEM_STAGE_ALIGN_CHECK_EN  defined: misaligned accesses are rejected and
//                             flagged on misalign_o. Undefined: the low two
//                             address bits are cleared and the access proceeds.
// -----------------------------------------------------------------------------

package mem_stage_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_or_mem_val;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_t     ex_mem_i,
  output mem_wb_t     mem_wb_o,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        bus_err_o
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op;
  logic        misalign;
  logic        access;
  logic        req;
  logic        timeout;
  logic        complete;
  logic        stall;

  assign mem_op = ex_mem_i.valid && (ex_mem_i.mem_read || ex_mem_i.mem_write);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign = mem_op && (ex_mem_i.alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned op never reaches the memory port.
  assign access = mem_op && !misalign;

  // The request stays up through the final watchdog cycle so that an ack
  // arriving there can still complete the access; it drops afterwards.
  // Gating with rst keeps the port quiet while a reset is in progress even
  // though upstream may still present a valid memory op.
  assign req      = !rst && (((state_q == IDLE) && access) || (state_q == WAIT));
  assign timeout  = !rst && (state_q == WAIT) && !dmem_ack_i && (wait_cnt_q == MAX_WAIT_C);
  assign complete = req && dmem_ack_i;
  assign stall    = req && !dmem_ack_i && !timeout;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      mem_wb_q   <= '0;
      bus_err_q  <= 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_wb_q   <= mem_wb_d;
      bus_err_q  <= bus_err_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (access && !dmem_ack_i) begin
          state_d    = WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      WAIT: begin
        if (dmem_ack_i || timeout) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wb_d  = '0;
    bus_err_d = timeout;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    misalign_d = misalign;
`endif
    if (stall) begin
      mem_wb_d = '0;
    end else if (complete) begin
      // A store never writes the register file, even if mem_read is also set.
      mem_wb_d.valid          = 1'b1;
      mem_wb_d.rd             = ex_mem_i.rd;
      mem_wb_d.reg_write      = ex_mem_i.reg_write && !ex_mem_i.mem_write;
      mem_wb_d.alu_or_mem_val = (ex_mem_i.mem_to_reg && !ex_mem_i.mem_write)
                                ? dmem_rdata_i : ex_mem_i.alu_result;
    end else if (timeout || misalign) begin
      // Abandoned access: the instruction retires without architectural effect.
      mem_wb_d.valid          = 1'b1;
      mem_wb_d.rd             = ex_mem_i.rd;
      mem_wb_d.reg_write      = 1'b0;
      mem_wb_d.alu_or_mem_val = ex_mem_i.alu_result;
    end else if (ex_mem_i.valid) begin
      mem_wb_d.valid          = 1'b1;
      mem_wb_d.rd             = ex_mem_i.rd;
      mem_wb_d.reg_write      = ex_mem_i.reg_write;
      mem_wb_d.alu_or_mem_val = ex_mem_i.alu_result;
    end
  end

  assign mem_wb_o     = mem_wb_q;
  assign bus_err_o    = bus_err_q;
  assign stall_o      = stall;
  assign dmem_req_o   = req;
  assign dmem_we_o    = !rst && ex_mem_i.valid && ex_mem_i.mem_write;
  assign dmem_wdata_o = (!rst && ex_mem_i.valid) ? ex_mem_i.rs2 : 32'd0;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign dmem_addr_o  = (!rst && ex_mem_i.valid) ? ex_mem_i.alu_result : 32'd0;
  assign misalign_o   = misalign_q;
`else
  // Without the alignment check, accesses are forced onto a word boundary.
  assign dmem_addr_o  = (!rst && ex_mem_i.valid) ? {ex_mem_i.alu_result[31:2], 2'b00} : 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        stall;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        bus_err;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    mem_wb_t exp;
    bit      full;   // 0: only valid and reg_write are defined
  } sb_t;
  sb_t sb_q[$];

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_i     (ex_mem),
    .mem_wb_o     (mem_wb),
    .stall_o      (stall),
    .dmem_req_o   (req),
    .dmem_we_o    (we),
    .dmem_addr_o  (addr),
    .dmem_wdata_o (wdata),
    .dmem_ack_i   (ack),
    .dmem_rdata_i (rdata),
    .bus_err_o    (bus_err)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    .misalign_o   (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s 0x%08h", name, act);
    end
  endfunction

  function automatic ex_mem_t mk(logic [31:0] alu, logic [31:0] rs2, logic [4:0] rd,
                                 logic rw, logic mr, logic mw, logic m2r);
    ex_mem_t e;
    e.valid      = 1'b1;
    e.alu_result = alu;
    e.rs2        = rs2;
    e.rd         = rd;
    e.reg_write  = rw;
    e.mem_read   = mr;
    e.mem_write  = mw;
    e.mem_to_reg = m2r;
    return e;
  endfunction

  function automatic void push(logic [31:0] val, logic [4:0] rd, logic rw, bit full);
    sb_t s;
    s.exp.valid          = 1'b1;
    s.exp.alu_or_mem_val = val;
    s.exp.rd             = rd;
    s.exp.reg_write      = rw;
    s.full               = full;
    sb_q.push_back(s);
  endfunction

  // Monitor: every valid MEM/WB entry is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_wb.valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected actual=%h required=no output", mem_wb);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        if (s.full ? (mem_wb !== s.exp)
                   : ({mem_wb.valid, mem_wb.reg_write} !== {s.exp.valid, s.exp.reg_write})) begin
          errors++;
          $display("FAIL mon_mem_wb actual=v%0b val=0x%08h rd=%0d rw=%0b required=v%0b val=0x%08h rd=%0d rw=%0b full=%0b",
                   mem_wb.valid, mem_wb.alu_or_mem_val, mem_wb.rd, mem_wb.reg_write,
                   s.exp.valid, s.exp.alu_or_mem_val, s.exp.rd, s.exp.reg_write, s.full);
        end else begin
          $display("ok   mon_mem_wb val=0x%08h rd=%0d rw=%0b", mem_wb.alu_or_mem_val, mem_wb.rd, mem_wb.reg_write);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst    = 1'b1;
    ex_mem = '0;
    ack    = 1'b0;
    rdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wb", 32'(mem_wb), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    tick();

    // ALU op: one-cycle pass-through, no stall.
    ex_mem = mk(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h1234, 5'd5, 1'b1, 1'b1);
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(req), 32'd0);
    tick();
    ex_mem = '0;
    tick();

    // Load at 0x100, ack three cycles after the first request.
    ex_mem = mk(32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_stall", 32'(stall), 32'd1);
      chk("ld_req", 32'(req), 32'd1);
      if (i == 0) begin
        chk("ld_we", 32'(we), 32'd0);
        chk("ld_addr", addr, 32'h100);
      end
      tick();
      chk("ld_bubble", 32'(mem_wb.valid), 32'd0);
    end
    ack   = 1'b1;
    rdata = 32'hDEADBEEF;
    push(32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
    #1;
    chk("ld_ack_stall", 32'(stall), 32'd0);
    tick();
    ex_mem = '0;
    ack    = 1'b0;
    rdata  = 32'd0;
    tick();

    // Zero-wait store.
    ex_mem = mk(32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    ack    = 1'b1;
    push(32'h40, 5'd0, 1'b0, 1'b1);
    #1;
    chk("st_we", 32'(we), 32'd1);
    chk("st_wdata", wdata, 32'hA5A5A5A5);
    chk("st_addr", addr, 32'h40);
    chk("st_stall", 32'(stall), 32'd0);
    tick();

    // Read and write both set: treated as a store, reg_write suppressed.
    ex_mem = mk(32'h80, 32'h12345678, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    rdata  = 32'h11111111;
    push(32'h80, 5'd8, 1'b0, 1'b1);
    #1;
    chk("rw_we", 32'(we), 32'd1);
    tick();
    ex_mem = '0;
    ack    = 1'b0;
    rdata  = 32'd0;
    tick();

    // Watchdog: MAX_WAIT=4, request high for 5 cycles then bus error.
    ex_mem = mk(32'h200, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("to_req", 32'(req), 32'd1);
      chk("to_stall", 32'(stall), (k < 4) ? 32'd1 : 32'd0);
      if (k == 4) push(32'h200, 5'd9, 1'b0, 1'b0);
      tick();
      if (k < 4) chk("to_no_err", 32'(bus_err), 32'd0);
    end
    chk("to_bus_err", 32'(bus_err), 32'd1);
    ex_mem = mk(32'hCAFE, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'hCAFE, 5'd3, 1'b1, 1'b1);
    #1;
    chk("to_req_drop", 32'(req), 32'd0);
    chk("to_next_stall", 32'(stall), 32'd0);
    tick();
    chk("to_err_pulse", 32'(bus_err), 32'd0);
    ex_mem = '0;
    tick();

    // Ack in the final watchdog cycle wins.
    ex_mem = mk(32'h300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      tick();
    end
    ack   = 1'b1;
    rdata = 32'h55AA55AA;
    push(32'h55AA55AA, 5'd4, 1'b1, 1'b1);
    #1;
    chk("late_ack_stall", 32'(stall), 32'd0);
    tick();
    chk("late_ack_no_err", 32'(bus_err), 32'd0);
    ex_mem = '0;
    ack    = 1'b0;
    rdata  = 32'd0;
    tick();

    // Reset during the second wait cycle of a load.
    ex_mem = mk(32'h100, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_mem_wb", 32'(mem_wb), 32'd0);
    #2;
    rst    = 1'b0;
    ex_mem = '0;
    tick();
    ack   = 1'b1;
    rdata = 32'h99999999;
    #1;
    chk("stray_ack_req", 32'(req), 32'd0);
    chk("stray_ack_stall", 32'(stall), 32'd0);
    tick();
    chk("stray_ack_bubble", 32'(mem_wb.valid), 32'd0);
    ack   = 1'b0;
    rdata = 32'd0;
    ex_mem = mk(32'h77, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h77, 5'd2, 1'b1, 1'b1);
    #1;
    chk("post_rst_stall", 32'(stall), 32'd0);
    tick();
    ex_mem = '0;
    tick();

    // Misaligned load at 0x102.
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ex_mem = mk(32'h102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h102, 5'd10, 1'b0, 1'b0);
    #1;
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    chk("mis_pulse", 32'(misalign), 32'd1);
    ex_mem = '0;
    tick();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
`else
    ex_mem = mk(32'h102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    ack    = 1'b1;
    rdata  = 32'h0BADF00D;
    push(32'h0BADF00D, 5'd10, 1'b1, 1'b1);
    #1;
    chk("unal_req", 32'(req), 32'd1);
    chk("unal_addr", addr, 32'h100);
    tick();
    ex_mem = '0;
    ack    = 1'b0;
    rdata  = 32'd0;
    tick();
`endif

    tick();
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
